// File: rtl/next_link_pkg.sv
//==============================================================================
// next_link_pkg: constants and types shared by the NeXT serial link TX and RX.
// Revision: 1.0
//==============================================================================
`default_nettype none

package next_link_pkg;

    localparam int              PACKET_BITS    = 41;
    localparam int              DATA_WIDTH     = 40;
    localparam logic [39:0]     AUDIO_REQ_CODE = 40'h07_0000_0000;
    localparam int              SENDER_GAP     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        GAP  = 2'd2
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/next_serial_receiver_if.sv
//==============================================================================
// next_serial_receiver_if: serial input plus packet output stream and status.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface next_serial_receiver_if #(
    parameter int DATA_WIDTH = 40
);
    logic                  sin;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  audio_req;
    logic                  framing_error;
    logic                  overrun;
    logic                  busy;

    modport master (
        input  sin, out_ready,
        output out_data, out_valid, audio_req, framing_error, overrun, busy
    );

    modport slave (
        output sin, out_ready,
        input  out_data, out_valid, audio_req, framing_error, overrun, busy
    );
endinterface

`default_nettype wire

// File: rtl/next_rx_holding_reg.sv
//==============================================================================
// next_rx_holding_reg: one-entry valid/ready output register with overrun pulse.
// Revision: 1.0
//==============================================================================
`default_nettype none

module next_rx_holding_reg #(
    parameter int DATA_WIDTH = 40
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  load,
    input  wire logic [DATA_WIDTH-1:0] load_data,
    input  wire logic                  ready,
    output logic      [DATA_WIDTH-1:0] data,
    output logic                       valid,
    output logic                       overrun
);

    always_ff @(posedge clk) begin
        if (rst) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                // A consume in the same cycle frees the slot, so the new packet is kept.
                if (!valid || ready) begin
                    data  <= load_data;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/next_serial_receiver.sv
//==============================================================================
// next_serial_receiver: NeXT serial link deserializer (start bit + 40 data bits).
// Optional audio-request decode: NEXT_RX_AUDIO_REQ_DECODE_EN.  Revision: 1.0
//==============================================================================
`default_nettype none

module next_serial_receiver
    import next_link_pkg::*;
#(
    parameter int                    DATA_WIDTH     = next_link_pkg::DATA_WIDTH,
    parameter int                    MIN_GAP        = next_link_pkg::SENDER_GAP,
    parameter logic [DATA_WIDTH-1:0] AUDIO_REQ_CODE = DATA_WIDTH'(next_link_pkg::AUDIO_REQ_CODE)
) (
    input wire logic              clk,
    input wire logic              rst,
    next_serial_receiver_if.master link
);

    localparam int CNT_MAX = (DATA_WIDTH > MIN_GAP) ? DATA_WIDTH : MIN_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((MIN_GAP > 0) ? (MIN_GAP - 1) : 0);

`ifdef NEXT_RX_AUDIO_REQ_DECODE_EN
    localparam bit DECODE_EN = 1'b1;
`else
    localparam bit DECODE_EN = 1'b0;
`endif

    rx_state_t             state;
    logic                  sin_q;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-2:0] shift;
    logic                  audio_req_q;
    logic                  framing_error_q;

    logic [DATA_WIDTH-1:0] payload;
    logic                  complete;
    logic                  audio_hit;
    logic                  load;

    // The last data bit is still in sin_q when the packet completes.
    assign payload   = {shift, sin_q};
    assign complete  = (state == DATA) && (cnt == DATA_LAST);
    assign audio_hit = DECODE_EN && (payload == AUDIO_REQ_CODE);
    assign load      = complete && !audio_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            sin_q           <= 1'b0;
            state           <= IDLE;
            cnt             <= '0;
            shift           <= '0;
            audio_req_q     <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            sin_q           <= link.sin;
            audio_req_q     <= 1'b0;
            framing_error_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (sin_q) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    shift <= payload[DATA_WIDTH-2:0];
                    if (cnt == DATA_LAST) begin
                        audio_req_q <= audio_hit;
                        cnt         <= '0;
                        state       <= (MIN_GAP == 0) ? IDLE : GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    // A premature start bit is flagged and dropped; the gap count keeps running.
                    framing_error_q <= sin_q;
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    next_rx_holding_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_holding (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (payload),
        .ready     (link.out_ready),
        .data      (link.out_data),
        .valid     (link.out_valid),
        .overrun   (link.overrun)
    );

    assign link.audio_req     = audio_req_q;
    assign link.framing_error = framing_error_q;
    assign link.busy          = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_next_serial_receiver.sv
//==============================================================================
// tb_next_serial_receiver: directed scoreboard bench for next_serial_receiver.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_next_serial_receiver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    next_serial_receiver_if #(.DATA_WIDTH(40)) link();

    next_serial_receiver dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [39:0] exp_q[$];
    logic [39:0] got_data [0:63];
    int          got_cyc  [0:63];
    int          got_cnt  = 0;
    int          rd       = 0;
    int          fe_cnt   = 0;
    int          ovr_cnt  = 0;
    int          aud_cnt  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every handshake and status pulse, sampled between active edges.
    always @(negedge clk) begin
        if (!rst) begin
            if (link.out_valid && link.out_ready) begin
                if (got_cnt < 64) begin
                    got_data[got_cnt] = link.out_data;
                    got_cyc[got_cnt]  = cyc;
                end
                got_cnt = got_cnt + 1;
            end
            if (link.framing_error) fe_cnt  = fe_cnt + 1;
            if (link.overrun)       ovr_cnt = ovr_cnt + 1;
            if (link.audio_req)     aud_cnt = aud_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_packet(input logic [39:0] p);
        tick; link.sin = 1'b1;
        for (int i = 39; i >= 0; i--) begin
            tick; link.sin = p[i];
        end
        tick; link.sin = 1'b0;
    endtask

    task automatic wait_got(input int n);
        for (int i = 0; i < 300 && got_cnt < n; i++) tick;
        check("wait_delivery", 64'(got_cnt >= n), 64'd1);
    endtask

    task automatic score(input string tag);
        check({tag, "_pending"}, 64'(exp_q.size() > 0 && got_cnt > rd), 64'd1);
        if (exp_q.size() > 0 && got_cnt > rd) begin
            check(tag, 64'(got_data[rd]), 64'(exp_q.pop_front()));
            rd = rd + 1;
        end
    endtask

    int base, fe0, ovr0, aud0;

    initial begin
        link.sin       = 1'b0;
        link.out_ready = 1'b0;
        rst            = 1'b1;
        repeat (3) tick;
        check("rst_data",   64'(link.out_data), 64'd0);
        check("rst_valid",  64'(link.out_valid), 64'd0);
        check("rst_status", 64'({link.audio_req, link.framing_error, link.overrun, link.busy}), 64'd0);
        rst = 1'b0;
        tick;

        // Held packet stays stable until consumed
        exp_q.push_back(40'hD9_9999_9999);
        send_packet(40'hD9_9999_9999);
        check("t1_early_valid", 64'(link.out_valid), 64'd0);
        check("t1_busy", 64'(link.busy), 64'd1);
        tick;
        check("t1_valid_T42", 64'(link.out_valid), 64'd1);
        check("t1_data_T42", 64'(link.out_data), 64'hD9_9999_9999);
        for (int i = 0; i < 20; i++) begin
            tick;
            check("t1_hold", 64'({link.out_valid, link.out_data}), 64'({1'b1, 40'hD9_9999_9999}));
        end
        link.out_ready = 1'b1;
        tick;
        link.out_ready = 1'b0;
        check("t1_valid_drop", 64'(link.out_valid), 64'd0);
        check("t1_one_delivery", 64'(got_cnt), 64'd1);
        score("t1_data");

        // Back-to-back with minimum gap
        link.out_ready = 1'b1;
        base = got_cnt; fe0 = fe_cnt; ovr0 = ovr_cnt;
        exp_q.push_back(40'h00_0000_0001);
        exp_q.push_back(40'h00_0000_0003);
        send_packet(40'h00_0000_0001);
        tick; tick;
        send_packet(40'h00_0000_0003);
        wait_got(base + 2);
        score("t2_first");
        score("t2_second");
        check("t2_spacing", 64'(got_cyc[base+1] - got_cyc[base]), 64'd44);
        check("t2_no_errors", 64'((fe_cnt - fe0) + (ovr_cnt - ovr0)), 64'd0);

        // Overrun: second packet dropped, first preserved
        link.out_ready = 1'b0;
        base = got_cnt; ovr0 = ovr_cnt;
        exp_q.push_back(40'h00_0000_0001);
        send_packet(40'h00_0000_0001);
        tick; tick;
        send_packet(40'h00_0000_0003);
        repeat (10) tick;
        check("t3_overrun_once", 64'(ovr_cnt - ovr0), 64'd1);
        check("t3_held", 64'({link.out_valid, link.out_data}), 64'({1'b1, 40'h00_0000_0001}));
        link.out_ready = 1'b1;
        wait_got(base + 1);
        score("t3_first_kept");
        repeat (5) tick;
        check("t3_no_second", 64'(got_cnt), 64'(base + 1));

        // Audio request packet
        link.out_ready = 1'b0;
        base = got_cnt; aud0 = aud_cnt;
        send_packet(40'h07_0000_0000);
        tick;
`ifdef NEXT_RX_AUDIO_REQ_DECODE_EN
        check("t4_audio_pulse", 64'(link.audio_req), 64'd1);
        check("t4_no_valid", 64'(link.out_valid), 64'd0);
        tick;
        check("t4_audio_clear", 64'(link.audio_req), 64'd0);
        check("t4_audio_count", 64'(aud_cnt - aud0), 64'd1);
`else
        exp_q.push_back(40'h07_0000_0000);
        check("t4_valid", 64'(link.out_valid), 64'd1);
        check("t4_data", 64'(link.out_data), 64'h07_0000_0000);
        check("t4_audio_tied", 64'(link.audio_req), 64'd0);
        link.out_ready = 1'b1;
        wait_got(base + 1);
        score("t4_delivered");
`endif

        // Framing error inside the gap
        link.out_ready = 1'b1;
        repeat (3) tick;
        base = got_cnt; fe0 = fe_cnt;
        exp_q.push_back(40'h5A_5A5A_5A5A);
        send_packet(40'h5A_5A5A_5A5A);
        tick; link.sin = 1'b1;
        tick; link.sin = 1'b0;
        tick;
        check("t5_fe_pulse", 64'(link.framing_error), 64'd1);
        tick;
        check("t5_fe_clear", 64'(link.framing_error), 64'd0);
        repeat (45) tick;
        check("t5_fe_once", 64'(fe_cnt - fe0), 64'd1);
        check("t5_no_spurious", 64'(got_cnt), 64'(base + 1));
        score("t5_data");
        check("t5_idle", 64'(link.busy), 64'd0);

        // Reset mid-packet discards partial and held packets
        link.out_ready = 1'b0;
        send_packet(40'hAA_AA00_AAAA);
        tick; tick;
        check("t6_held", 64'(link.out_valid), 64'd1);
        tick; link.sin = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick; link.sin = i[0];
        end
        check("t6_busy", 64'(link.busy), 64'd1);
        rst = 1'b1; link.sin = 1'b0;
        tick; tick;
        check("t6_rst_valid", 64'(link.out_valid), 64'd0);
        check("t6_rst_data", 64'(link.out_data), 64'd0);
        check("t6_rst_busy", 64'(link.busy), 64'd0);
        rst = 1'b0;
        link.out_ready = 1'b1;
        base = got_cnt;
        repeat (3) tick;
        check("t6_nothing_after_rst", 64'(got_cnt), 64'(base));
        exp_q.push_back(40'h00_0000_00FF);
        send_packet(40'h00_0000_00FF);
        wait_got(base + 1);
        score("t6_clean");
        repeat (50) tick;
        check("t6_only_one", 64'(got_cnt), 64'(base + 1));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
